// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the CPU-to-DDR memory arbiter.
// Optional build macro used by the arbiter: MEM_ARB_ROUND_ROBIN_EN.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        RDWAIT = 2'd2,
        ACK    = 2'd3
    } state_t;

    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_D  = 1'b1;

    localparam int LANES  = 4;
    localparam int LANE_W = 2;
    localparam int BE_W   = 16;

    // Byte enables covering one 32-bit lane of the 128-bit line.
    function automatic logic [BE_W-1:0] write_be(input logic [LANE_W-1:0] lane);
        return 16'h000F << {lane, 2'b00};
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Two-way requester picker for the memory arbiter.
// MEM_ARB_ROUND_ROBIN_EN defined: ties go to the port not served last.
// MEM_ARB_ROUND_ROBIN_EN undefined: the data port always wins ties.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic if_req,
    input  logic d_req,
    input  logic last_grant,
    output logic winner,
    output logic valid
);

    // Choose the winning port among the active requests
    always_comb begin
        valid  = if_req | d_req;
        winner = PORT_D;
        if (if_req && d_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            winner = (last_grant == PORT_D) ? PORT_IF : PORT_D;
`else
            winner = PORT_D;
`endif
        end else if (if_req) begin
            winner = PORT_IF;
        end else begin
            winner = PORT_D;
        end
    end

`ifndef MEM_ARB_ROUND_ROBIN_EN
    logic unused_s;
    assign unused_s = last_grant;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares one Avalon-MM DDR port (128-bit lines) between the CPU fetch port
// and the CPU load/store port. One transaction at a time, req/ack per port.
// Build macro: MEM_ARB_ROUND_ROBIN_EN selects round-robin tie breaking;
// without it the data port has fixed priority.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int RAM_ADDR_W = 26,
    parameter int RAM_DATA_W = 128,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32
) (
    input  logic                  iCLK,
    input  logic                  iRST,
    input  logic                  if_req,
    input  logic [ADDR_W-1:0]     if_addr,
    output logic [DATA_W-1:0]     if_rdata,
    output logic                  if_ack,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    output logic [DATA_W-1:0]     d_rdata,
    output logic                  d_ack,
    output logic                  busy,
    input  logic                  avl_wait,
    input  logic                  avl_readdatavalid,
    input  logic [RAM_DATA_W-1:0] avl_readdata,
    output logic                  avl_read,
    output logic                  avl_write,
    output logic [RAM_ADDR_W-1:0] avl_address,
    output logic [RAM_DATA_W-1:0] avl_writedata,
    output logic [BE_W-1:0]       avl_byteenable
);

    state_t state_r, state_next_s;

    logic pick_valid_s, pick_id_s, last_grant_s;
    logic grant_r, we_r;
    logic [LANE_W-1:0] lane_r;

    logic              sel_we_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [DATA_W-1:0] sel_wdata_s;
    logic [LANE_W-1:0] sel_lane_s;
    logic [DATA_W-1:0] rd_word_s;

    logic                  avl_read_next_s, avl_write_next_s;
    logic [RAM_ADDR_W-1:0] avl_address_next_s;
    logic [RAM_DATA_W-1:0] avl_writedata_next_s;
    logic [BE_W-1:0]       avl_byteenable_next_s;
    logic                  if_ack_next_s, d_ack_next_s;
    logic [DATA_W-1:0]     if_rdata_next_s, d_rdata_next_s;

    logic grant_now_s;
    assign grant_now_s = (state_r == IDLE) && pick_valid_s;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic last_grant_r;

    // Remember the port served last so simultaneous requests alternate
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            last_grant_r <= PORT_D;
        end else if (grant_now_s) begin
            last_grant_r <= pick_id_s;
        end else begin
            last_grant_r <= last_grant_r;
        end
    end
    assign last_grant_s = last_grant_r;
`else
    assign last_grant_s = PORT_D;
`endif

    mem_arb_pick u_pick (
        .if_req     (if_req),
        .d_req      (d_req),
        .last_grant (last_grant_s),
        .winner     (pick_id_s),
        .valid      (pick_valid_s)
    );

    // Steer the winning requester's fields toward the grant latch
    always_comb begin
        if (pick_id_s == PORT_D) begin
            sel_we_s    = d_we;
            sel_addr_s  = d_addr;
            sel_wdata_s = d_wdata;
        end else begin
            sel_we_s    = 1'b0;
            sel_addr_s  = if_addr;
            sel_wdata_s = {DATA_W{1'b0}};
        end
    end

    assign sel_lane_s = sel_addr_s[3:2];
    assign rd_word_s  = avl_readdata[DATA_W*lane_r +: DATA_W];

    // Byte offset and bits above the line address are not used
    logic unused_s;
    assign unused_s = ^{sel_addr_s[1:0], sel_addr_s[ADDR_W-1:RAM_ADDR_W+4]};

    // Latch who was granted and the shape of its access
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            grant_r <= PORT_IF;
            we_r    <= 1'b0;
            lane_r  <= {LANE_W{1'b0}};
        end else if (grant_now_s) begin
            grant_r <= pick_id_s;
            we_r    <= sel_we_s;
            lane_r  <= sel_lane_s;
        end else begin
            grant_r <= grant_r;
            we_r    <= we_r;
            lane_r  <= lane_r;
        end
    end

    // State register
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic: grant, wait for acceptance, wait for read data, ack
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE:    state_next_s = pick_valid_s ? ISSUE : IDLE;
            ISSUE: begin
                if (!avl_wait) begin
                    state_next_s = we_r ? ACK : RDWAIT;
                end else begin
                    state_next_s = ISSUE;
                end
            end
            RDWAIT:  state_next_s = avl_readdatavalid ? ACK : RDWAIT;
            ACK:     state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Next values of the registered outputs for the current state
    always_comb begin
        avl_read_next_s       = avl_read;
        avl_write_next_s      = avl_write;
        avl_address_next_s    = avl_address;
        avl_writedata_next_s  = avl_writedata;
        avl_byteenable_next_s = avl_byteenable;
        if_ack_next_s         = 1'b0;
        d_ack_next_s          = 1'b0;
        if_rdata_next_s       = if_rdata;
        d_rdata_next_s        = d_rdata;
        case (state_r)
            IDLE: begin
                if (pick_valid_s) begin
                    avl_read_next_s       = ~sel_we_s;
                    avl_write_next_s      = sel_we_s;
                    avl_address_next_s    = sel_addr_s[RAM_ADDR_W+3:4];
                    avl_writedata_next_s  = {LANES{sel_wdata_s}};
                    avl_byteenable_next_s = sel_we_s ? write_be(sel_lane_s) : {BE_W{1'b1}};
                end else begin
                    avl_read_next_s  = 1'b0;
                    avl_write_next_s = 1'b0;
                end
            end
            ISSUE: begin
                if (!avl_wait) begin
                    avl_read_next_s  = 1'b0;
                    avl_write_next_s = 1'b0;
                    if (we_r) begin
                        if_ack_next_s = (grant_r == PORT_IF);
                        d_ack_next_s  = (grant_r == PORT_D);
                    end else begin
                        if_ack_next_s = 1'b0;
                        d_ack_next_s  = 1'b0;
                    end
                end else begin
                    avl_read_next_s  = avl_read;
                    avl_write_next_s = avl_write;
                end
            end
            RDWAIT: begin
                if (avl_readdatavalid) begin
                    if (grant_r == PORT_IF) begin
                        if_rdata_next_s = rd_word_s;
                        if_ack_next_s   = 1'b1;
                    end else begin
                        d_rdata_next_s  = rd_word_s;
                        d_ack_next_s    = 1'b1;
                    end
                end else begin
                    if_ack_next_s = 1'b0;
                    d_ack_next_s  = 1'b0;
                end
            end
            ACK: begin
                avl_read_next_s  = 1'b0;
                avl_write_next_s = 1'b0;
            end
            default: begin
                avl_read_next_s  = 1'b0;
                avl_write_next_s = 1'b0;
            end
        endcase
    end

    // Output registers; reset abandons any transaction in flight
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            avl_read       <= 1'b0;
            avl_write      <= 1'b0;
            avl_address    <= {RAM_ADDR_W{1'b0}};
            avl_writedata  <= {RAM_DATA_W{1'b0}};
            avl_byteenable <= {BE_W{1'b0}};
            if_ack         <= 1'b0;
            d_ack          <= 1'b0;
            if_rdata       <= {DATA_W{1'b0}};
            d_rdata        <= {DATA_W{1'b0}};
            busy           <= 1'b0;
        end else begin
            avl_read       <= avl_read_next_s;
            avl_write      <= avl_write_next_s;
            avl_address    <= avl_address_next_s;
            avl_writedata  <= avl_writedata_next_s;
            avl_byteenable <= avl_byteenable_next_s;
            if_ack         <= if_ack_next_s;
            d_ack          <= d_ack_next_s;
            if_rdata       <= if_rdata_next_s;
            d_rdata        <= d_rdata_next_s;
            busy           <= (state_next_s != IDLE);
        end
    end

endmodule
